bp_cfg_link_endpoint: RTL
=========================

Name: bp_cfg_link_endpoint

Overview:
Parametrised config-link slave terminating one tile's configuration channel. Accepts read/write commands on a valid/ready port and decodes a 16-bit offset inside a base-matched window. Serves local config registers directly: reset, freeze, core/cache/CCE ids and modes, npc, priv, IRF writes. Forwards the CSR window and the CCE-ucode window to a downstream port, and returns exactly one response per command.

Parameters:
addr_width_p, 32, width of cfg_addr_i
data_width_p, 64, command/response data width
base_addr_p, 'h0100_0000, window base; cfg_addr_i[addr_width_p-1:16] must equal base_addr_p[addr_width_p-1:16]
vaddr_width_p, 39, npc width
id_width_p, 4, width of core_id/icache_id/dcache_id/cce_id
lce_cnt_width_p, 8, width of num_lce register
timeout_cycles_p, 1024, forward-wait limit (optional feature only)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  async active-low reset
cfg_v_i  in  1  command valid
cfg_w_i  in  1  1=write, 0=read
cfg_addr_i  in  addr_width_p  command address
cfg_data_i  in  data_width_p  write data
cfg_ready_o  out  1  command accepted when cfg_v_i & cfg_ready_o
resp_v_o  out  1  response valid
resp_data_o  out  data_width_p  read data (0 for writes/errors)
resp_err_o  out  1  decode/access/timeout error
resp_yumi_i  in  1  response consumed
reset_o, freeze_o  out  1 each  core reset / freeze
core_id_o, icache_id_o, dcache_id_o, cce_id_o  out  id_width_p each
icache_mode_o, dcache_mode_o, cce_mode_o  out  2 each  mode fields
priv_o  out  2  privilege at release
num_lce_o  out  lce_cnt_width_p  LCE count
npc_o  out  vaddr_width_p  start PC
npc_w_v_o  out  1  one-cycle pulse on npc write
irf_w_v_o  out  1  one-cycle IRF write pulse
irf_addr_o  out  5  IRF index
irf_data_o  out  data_width_p  IRF data
fwd_v_o  out  1  forward request valid
fwd_sel_o  out  1  0=CSR window, 1=ucode window
fwd_w_o  out  1  forward write
fwd_addr_o  out  12  offset[11:0]
fwd_data_o  out  data_width_p  forward write data
fwd_ready_i  in  1  downstream accepts request
fwd_resp_v_i  in  1  downstream response (reads and writes)
fwd_resp_data_i  in  data_width_p  downstream read data

Behaviour:
- Decode offsets: 0x0001 reset, 0x0002 freeze, 0x0003 core_id, 0x0021 icache_id, 0x0022 icache_mode, 0x0040 npc, 0x0041 dcache_id, 0x0042 dcache_mode, 0x0043 priv, 0x0050-0x006F IRF x0-x31 (write-only), 0x0080 cce_id, 0x0081 cce_mode, 0x0082 num_lce, 0x6000-0x6FFF CSR fwd, 0x8000-0x8FFF ucode fwd.
- Error case: any other offset, a base mismatch, or a read of the IRF -> resp_err_o=1, resp_data_o=0, no side effect.
- Reset values: reset_o=1, freeze_o=1; all ids, modes, priv, num_lce and npc =0; all pulses, resp_v_o and fwd_v_o =0; FSM=IDLE.
- FSM states: IDLE, FWD_REQ, FWD_WAIT, RESP.
- cfg_ready_o=1 only in IDLE.
- Local command accepted in cycle N: register update visible at N+1; FSM->RESP; resp_v_o=1 from N+1.
- Writes take the LSBs of cfg_data_i; reads zero-extend.
- npc_w_v_o and irf_w_v_o assert in cycle N+1 only.
- Forward command: IDLE->FWD_REQ. fwd_v_o=1 with stable fields until fwd_ready_i, then ->FWD_WAIT.
- FWD_WAIT: on fwd_resp_v_i, capture data (0 for writes), ->RESP.
- fwd_resp_v_i in any other state is ignored.
- RESP: hold resp_* stable until resp_yumi_i, then ->IDLE. Next accept is possible the following cycle.
- Each command produces exactly one response, in order; no pipelining.
- Async reset in any state: immediately restore reset values; an in-flight forward is abandoned.

Optional Feature:
BP_CFG_LINK_TIMEOUT_EN:
- Defined: a counter clears on entry to FWD_WAIT and increments each cycle there. Reaching timeout_cycles_p with no fwd_resp_v_i -> RESP with resp_err_o=1, data 0.
- Undefined: FWD_WAIT waits indefinitely; no counter is synthesised.

Test Plan:
- Release reset, idle 5 cycles -> reset_o=1, freeze_o=1, npc_o=0, cfg_ready_o=1, resp_v_o=0.
- Write 0x0100_0040 data 0x8000_0000 -> npc_o=0x8000_0000 and npc_w_v_o high one cycle; read back returns 0x8000_0000, err=0.
- Write 0x0100_0002=0, then read 0x0100_0002 with resp_yumi_i withheld 3 cycles -> freeze_o=0; resp held stable 3 cycles with data 0; cfg_ready_o=0 until yumi.
- Read 0x0100_6005 with fwd_ready_i delayed 2 cycles, resp data 0xABCD -> fwd_sel_o=0, fwd_addr_o=0x005; resp_data_o=0xABCD.
- Read 0x0100_0055, write 0x0100_9000, write 0x0200_0001 -> all resp_err_o=1, data 0, reset_o unchanged.
- With BP_CFG_LINK_TIMEOUT_EN, timeout_cycles_p=16: write 0x0100_8010 with no fwd_resp_v_i -> error response exactly 16 cycles after FWD_WAIT entry. Also: assert reset_n_i mid-FWD_REQ -> fwd_v_o=0 immediately, FSM IDLE.

Source files
------------

// File: rtl/bp_cfg_link_endpoint.sv
// Config-link slave for one tile: serves local config registers and forwards CSR/ucode windows downstream.
// Optional forward-wait timeout is enabled by defining BP_CFG_LINK_TIMEOUT_EN.
module bp_cfg_link_endpoint #(
   parameter int                      addr_width_p     = 32,
   parameter int                      data_width_p     = 64,
   parameter logic [addr_width_p-1:0] base_addr_p      = 32'h0100_0000,
   parameter int                      vaddr_width_p    = 39,
   parameter int                      id_width_p       = 4,
   parameter int                      lce_cnt_width_p  = 8,
   parameter int                      timeout_cycles_p = 1024
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       cfg_v_i,
   input  logic                       cfg_w_i,
   input  logic [addr_width_p-1:0]    cfg_addr_i,
   input  logic [data_width_p-1:0]    cfg_data_i,
   output logic                       cfg_ready_o,
   output logic                       resp_v_o,
   output logic [data_width_p-1:0]    resp_data_o,
   output logic                       resp_err_o,
   input  logic                       resp_yumi_i,
   output logic                       reset_o,
   output logic                       freeze_o,
   output logic [id_width_p-1:0]      core_id_o,
   output logic [id_width_p-1:0]      icache_id_o,
   output logic [id_width_p-1:0]      dcache_id_o,
   output logic [id_width_p-1:0]      cce_id_o,
   output logic [1:0]                 icache_mode_o,
   output logic [1:0]                 dcache_mode_o,
   output logic [1:0]                 cce_mode_o,
   output logic [1:0]                 priv_o,
   output logic [lce_cnt_width_p-1:0] num_lce_o,
   output logic [vaddr_width_p-1:0]   npc_o,
   output logic                       npc_w_v_o,
   output logic                       irf_w_v_o,
   output logic [4:0]                 irf_addr_o,
   output logic [data_width_p-1:0]    irf_data_o,
   output logic                       fwd_v_o,
   output logic                       fwd_sel_o,
   output logic                       fwd_w_o,
   output logic [11:0]                fwd_addr_o,
   output logic [data_width_p-1:0]    fwd_data_o,
   input  logic                       fwd_ready_i,
   input  logic                       fwd_resp_v_i,
   input  logic [data_width_p-1:0]    fwd_resp_data_i
);

   typedef enum logic [1:0] {IDLE, FWD_REQ, FWD_WAIT, RESP} state_e;
   typedef enum logic [3:0] {
      SEL_NONE, SEL_RESET, SEL_FREEZE, SEL_CORE_ID, SEL_IC_ID, SEL_IC_MODE, SEL_NPC, SEL_DC_ID,
      SEL_DC_MODE, SEL_PRIV, SEL_IRF, SEL_CCE_ID, SEL_CCE_MODE, SEL_NUM_LCE, SEL_CSR, SEL_UCODE
   } sel_e;

   state_e                     state_q;
   sel_e                       sel_s;
   logic [15:0]                offset_s;
   logic                       err_s, fwd_hit_s;
   logic [data_width_p-1:0]    rdata_s;
   logic                       cfg_ready_q, resp_v_q, resp_err_q;
   logic [data_width_p-1:0]    resp_data_q;
   logic                       reset_q, freeze_q, npc_w_v_q, irf_w_v_q;
   logic [id_width_p-1:0]      core_id_q, icache_id_q, dcache_id_q, cce_id_q;
   logic [1:0]                 icache_mode_q, dcache_mode_q, cce_mode_q, priv_q;
   logic [lce_cnt_width_p-1:0] num_lce_q;
   logic [vaddr_width_p-1:0]   npc_q;
   logic [4:0]                 irf_addr_q;
   logic [data_width_p-1:0]    irf_data_q, fwd_data_q;
   logic                       fwd_v_q, fwd_sel_q, fwd_w_q;
   logic [11:0]                fwd_addr_q;
`ifdef BP_CFG_LINK_TIMEOUT_EN
   localparam int cnt_w_lp = $clog2(timeout_cycles_p + 1);
   logic [cnt_w_lp-1:0]        cnt_q;
`endif

   // Address decode and local read-data mux for the command currently presented.
   always_comb begin
      offset_s = cfg_addr_i[15:0];
      sel_s    = SEL_NONE;
      rdata_s  = '0;
      case (offset_s)
         16'h0001: sel_s = SEL_RESET;
         16'h0002: sel_s = SEL_FREEZE;
         16'h0003: sel_s = SEL_CORE_ID;
         16'h0021: sel_s = SEL_IC_ID;
         16'h0022: sel_s = SEL_IC_MODE;
         16'h0040: sel_s = SEL_NPC;
         16'h0041: sel_s = SEL_DC_ID;
         16'h0042: sel_s = SEL_DC_MODE;
         16'h0043: sel_s = SEL_PRIV;
         16'h0080: sel_s = SEL_CCE_ID;
         16'h0081: sel_s = SEL_CCE_MODE;
         16'h0082: sel_s = SEL_NUM_LCE;
         default: begin
            if (offset_s >= 16'h0050 && offset_s <= 16'h006F) sel_s = SEL_IRF;
            else if (offset_s[15:12] == 4'h6)                 sel_s = SEL_CSR;
            else if (offset_s[15:12] == 4'h8)                 sel_s = SEL_UCODE;
            else                                              sel_s = SEL_NONE;
         end
      endcase
      if (cfg_addr_i[addr_width_p-1:16] != base_addr_p[addr_width_p-1:16]) sel_s = SEL_NONE;
      else sel_s = sel_s;
      case (sel_s)
         SEL_RESET:    rdata_s[0]                   = reset_q;
         SEL_FREEZE:   rdata_s[0]                   = freeze_q;
         SEL_CORE_ID:  rdata_s[id_width_p-1:0]      = core_id_q;
         SEL_IC_ID:    rdata_s[id_width_p-1:0]      = icache_id_q;
         SEL_IC_MODE:  rdata_s[1:0]                 = icache_mode_q;
         SEL_NPC:      rdata_s[vaddr_width_p-1:0]   = npc_q;
         SEL_DC_ID:    rdata_s[id_width_p-1:0]      = dcache_id_q;
         SEL_DC_MODE:  rdata_s[1:0]                 = dcache_mode_q;
         SEL_PRIV:     rdata_s[1:0]                 = priv_q;
         SEL_CCE_ID:   rdata_s[id_width_p-1:0]      = cce_id_q;
         SEL_CCE_MODE: rdata_s[1:0]                 = cce_mode_q;
         SEL_NUM_LCE:  rdata_s[lce_cnt_width_p-1:0] = num_lce_q;
         default:      rdata_s                      = '0;
      endcase
      fwd_hit_s = (sel_s == SEL_CSR) || (sel_s == SEL_UCODE);
      err_s     = (sel_s == SEL_NONE) || ((sel_s == SEL_IRF) && !cfg_w_i);
   end

   // Command FSM, config registers and all registered outputs.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         cfg_ready_q   <= 1'b1;
         resp_v_q      <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_data_q   <= '0;
         reset_q       <= 1'b1;
         freeze_q      <= 1'b1;
         core_id_q     <= '0;
         icache_id_q   <= '0;
         dcache_id_q   <= '0;
         cce_id_q      <= '0;
         icache_mode_q <= 2'b00;
         dcache_mode_q <= 2'b00;
         cce_mode_q    <= 2'b00;
         priv_q        <= 2'b00;
         num_lce_q     <= '0;
         npc_q         <= '0;
         npc_w_v_q     <= 1'b0;
         irf_w_v_q     <= 1'b0;
         irf_addr_q    <= 5'd0;
         irf_data_q    <= '0;
         fwd_v_q       <= 1'b0;
         fwd_sel_q     <= 1'b0;
         fwd_w_q       <= 1'b0;
         fwd_addr_q    <= 12'h000;
         fwd_data_q    <= '0;
`ifdef BP_CFG_LINK_TIMEOUT_EN
         cnt_q         <= '0;
`endif
      end else begin
         npc_w_v_q <= 1'b0;
         irf_w_v_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_v_i) begin
                  cfg_ready_q <= 1'b0;
                  if (fwd_hit_s) begin
                     state_q    <= FWD_REQ;
                     fwd_v_q    <= 1'b1;
                     fwd_sel_q  <= (sel_s == SEL_UCODE);
                     fwd_w_q    <= cfg_w_i;
                     fwd_addr_q <= offset_s[11:0];
                     fwd_data_q <= cfg_data_i;
                  end else begin
                     state_q     <= RESP;
                     resp_v_q    <= 1'b1;
                     resp_err_q  <= err_s;
                     resp_data_q <= (err_s || cfg_w_i) ? '0 : rdata_s;
                     if (cfg_w_i && !err_s) begin
                        case (sel_s)
                           SEL_RESET:    reset_q       <= cfg_data_i[0];
                           SEL_FREEZE:   freeze_q      <= cfg_data_i[0];
                           SEL_CORE_ID:  core_id_q     <= cfg_data_i[id_width_p-1:0];
                           SEL_IC_ID:    icache_id_q   <= cfg_data_i[id_width_p-1:0];
                           SEL_IC_MODE:  icache_mode_q <= cfg_data_i[1:0];
                           SEL_DC_ID:    dcache_id_q   <= cfg_data_i[id_width_p-1:0];
                           SEL_DC_MODE:  dcache_mode_q <= cfg_data_i[1:0];
                           SEL_PRIV:     priv_q        <= cfg_data_i[1:0];
                           SEL_CCE_ID:   cce_id_q      <= cfg_data_i[id_width_p-1:0];
                           SEL_CCE_MODE: cce_mode_q    <= cfg_data_i[1:0];
                           SEL_NUM_LCE:  num_lce_q     <= cfg_data_i[lce_cnt_width_p-1:0];
                           SEL_NPC: begin
                              npc_q     <= cfg_data_i[vaddr_width_p-1:0];
                              npc_w_v_q <= 1'b1;
                           end
                           SEL_IRF: begin
                              // 0x50..0x6F maps to x0..x31: bit 4 of the offset is inverted
                              irf_addr_q <= {~offset_s[4], offset_s[3:0]};
                              irf_data_q <= cfg_data_i;
                              irf_w_v_q  <= 1'b1;
                           end
                           default: begin end
                        endcase
                     end
                  end
               end
            end
            FWD_REQ: begin
               if (fwd_ready_i) begin
                  fwd_v_q <= 1'b0;
                  state_q <= FWD_WAIT;
`ifdef BP_CFG_LINK_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            FWD_WAIT: begin
               if (fwd_resp_v_i) begin
                  state_q     <= RESP;
                  resp_v_q    <= 1'b1;
                  resp_err_q  <= 1'b0;
                  resp_data_q <= fwd_w_q ? '0 : fwd_resp_data_i;
               end
`ifdef BP_CFG_LINK_TIMEOUT_EN
               else if (cnt_q == cnt_w_lp'(timeout_cycles_p - 1)) begin
                  state_q     <= RESP;
                  resp_v_q    <= 1'b1;
                  resp_err_q  <= 1'b1;
                  resp_data_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            RESP: begin
               if (resp_yumi_i) begin
                  state_q     <= IDLE;
                  resp_v_q    <= 1'b0;
                  resp_err_q  <= 1'b0;
                  resp_data_q <= '0;
                  cfg_ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_ready_o   = cfg_ready_q;
   assign resp_v_o      = resp_v_q;
   assign resp_err_o    = resp_err_q;
   assign resp_data_o   = resp_data_q;
   assign reset_o       = reset_q;
   assign freeze_o      = freeze_q;
   assign core_id_o     = core_id_q;
   assign icache_id_o   = icache_id_q;
   assign dcache_id_o   = dcache_id_q;
   assign cce_id_o      = cce_id_q;
   assign icache_mode_o = icache_mode_q;
   assign dcache_mode_o = dcache_mode_q;
   assign cce_mode_o    = cce_mode_q;
   assign priv_o        = priv_q;
   assign num_lce_o     = num_lce_q;
   assign npc_o         = npc_q;
   assign npc_w_v_o     = npc_w_v_q;
   assign irf_w_v_o     = irf_w_v_q;
   assign irf_addr_o    = irf_addr_q;
   assign irf_data_o    = irf_data_q;
   assign fwd_v_o       = fwd_v_q;
   assign fwd_sel_o     = fwd_sel_q;
   assign fwd_w_o       = fwd_w_q;
   assign fwd_addr_o    = fwd_addr_q;
   assign fwd_data_o    = fwd_data_q;

endmodule
